load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// load_store_unit -- single-outstanding data-memory access unit: lane steering,
// load extension, misalignment and bus-timeout detection.          Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package load_store_unit_pkg;
  typedef enum logic [2:0] {
    BYTE_SIGNED        = 3'd0,
    BYTE_UNSIGNED      = 3'd1,
    HALF_WORD_SIGNED   = 3'd2,
    HALF_WORD_UNSIGNED = 3'd3,
    ORIGIN_WORD        = 3'd4
  } read_type_t;

  typedef enum logic [1:0] {
    WRITE_NONE      = 2'd0,
    WRITE_BYTE      = 2'd1,
    WRITE_HALF_WORD = 2'd2,
    WRITE_WORD      = 2'd3
  } write_type_t;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqRead,
  input  logic [31:0] reqAddress,
  input  read_type_t  reqReadType,
  input  write_type_t reqWriteType,
  input  logic [31:0] reqWriteValue,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic        busy,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memWriteData,
  input  logic        memAck,
  input  logic [31:0] memReadData
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_count;
  logic        r_read;
  logic [1:0]  r_addrLow;
  read_type_t  r_readType;

  logic        w_isHalf;
  logic        w_isWord;
  logic        w_misaligned;
  logic        w_noWrite;
  logic [3:0]  w_enable;
  logic [31:0] w_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  // Classification is done on the live request so the first transition is already correct.
  always_comb begin
    w_isHalf = reqRead ? (reqReadType == HALF_WORD_SIGNED || reqReadType == HALF_WORD_UNSIGNED)
                       : (reqWriteType == WRITE_HALF_WORD);
    w_isWord = reqRead ? (reqReadType == ORIGIN_WORD) : (reqWriteType == WRITE_WORD);
    w_misaligned = (w_isHalf && reqAddress[0]) || (w_isWord && (reqAddress[1:0] != 2'b00));
    w_noWrite = !reqRead && (reqWriteType == WRITE_NONE);
  end

  always_comb begin
    w_enable = 4'b0000;
    w_data   = 32'h0;
    case (reqWriteType)
      WRITE_BYTE: begin
        w_enable = 4'b0001 << reqAddress[1:0];
        w_data   = {4{reqWriteValue[7:0]}};
      end
      WRITE_HALF_WORD: begin
        w_enable = reqAddress[1] ? 4'b1100 : 4'b0011;
        w_data   = {2{reqWriteValue[15:0]}};
      end
      WRITE_WORD: begin
        w_enable = 4'b1111;
        w_data   = reqWriteValue;
      end
      default: begin
        w_enable = 4'b0000;
        w_data   = 32'h0;
      end
    endcase
  end

  always_comb begin
    case (r_addrLow)
      2'd0:    w_byte = memReadData[7:0];
      2'd1:    w_byte = memReadData[15:8];
      2'd2:    w_byte = memReadData[23:16];
      default: w_byte = memReadData[31:24];
    endcase
    w_half = r_addrLow[1] ? memReadData[31:16] : memReadData[15:0];
    case (r_readType)
      BYTE_SIGNED:        w_loadData = {{24{w_byte[7]}}, w_byte};
      BYTE_UNSIGNED:      w_loadData = {24'h0, w_byte};
      HALF_WORD_SIGNED:   w_loadData = {{16{w_half[15]}}, w_half};
      HALF_WORD_UNSIGNED: w_loadData = {16'h0, w_half};
      default:            w_loadData = memReadData;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_read        <= 1'b0;
      r_addrLow     <= 2'b00;
      r_readType    <= BYTE_SIGNED;
      reqReady      <= 1'b1;
      busy          <= 1'b0;
      memReq        <= 1'b0;
      memWrite      <= 1'b0;
      memAddress    <= 32'h0;
      memByteEnable <= 4'b0000;
      memWriteData  <= 32'h0;
      respValid     <= 1'b0;
      respData      <= 32'h0;
      respError     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (reqValid) begin
            r_read     <= reqRead;
            r_addrLow  <= reqAddress[1:0];
            r_readType <= reqReadType;
            reqReady   <= 1'b0;
            busy       <= 1'b1;
            if (w_misaligned || w_noWrite) begin
              r_state   <= RESP;
              respValid <= 1'b1;
              respData  <= 32'h0;
              respError <= w_misaligned;
            end else begin
              r_state       <= ISSUE;
              r_count       <= '0;
              memReq        <= 1'b1;
              memWrite      <= !reqRead;
              memAddress    <= {reqAddress[31:2], 2'b00};
              memByteEnable <= reqRead ? 4'b0000 : w_enable;
              memWriteData  <= reqRead ? 32'h0 : w_data;
            end
          end
        end
        ISSUE: begin
          // An ack on the timeout cycle still completes the access normally.
          if (memAck || (r_count == c_LAST)) begin
            r_state       <= RESP;
            memReq        <= 1'b0;
            memWrite      <= 1'b0;
            memAddress    <= 32'h0;
            memByteEnable <= 4'b0000;
            memWriteData  <= 32'h0;
            respValid     <= 1'b1;
            respData      <= (memAck && r_read) ? w_loadData : 32'h0;
            respError     <= !memAck;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          reqReady  <= 1'b1;
          busy      <= 1'b0;
          respValid <= 1'b0;
          respData  <= 32'h0;
          respError <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected bus and
// response records; negedge monitors pop and compare.
`default_nettype none

module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqRead;
  logic [31:0] reqAddress;
  read_type_t  reqReadType;
  write_type_t reqWriteType;
  logic [31:0] reqWriteValue;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic        busy;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [3:0]  memByteEnable;
  logic [31:0] memWriteData;
  logic        memAck;
  logic [31:0] memReadData;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqRead(reqRead),
    .reqAddress(reqAddress), .reqReadType(reqReadType), .reqWriteType(reqWriteType),
    .reqWriteValue(reqWriteValue),
    .respValid(respValid), .respData(respData), .respError(respError), .busy(busy),
    .memReq(memReq), .memWrite(memWrite), .memAddress(memAddress),
    .memByteEnable(memByteEnable), .memWriteData(memWriteData),
    .memAck(memAck), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wr;
    int          len;
    int          start;
  } bus_t;

  resp_t respQ[$];
  bus_t  busQ[$];
  bus_t  cur;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    busLen = 0;
  int    ackDelay = -1;
  logic [31:0] ackData = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Response monitor and bus responder share the negedge so the cycle count is coherent.
  always @(negedge clock) begin
    resp_t r;
    cyc++;
    if (respValid) begin
      if (respQ.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        r = respQ.pop_front();
        check("resp_data", respData, r.data);
        check("resp_error", {31'h0, respError}, {31'h0, r.err});
        check("resp_cycle", cyc, r.cyc);
      end
    end else if (respData != 32'h0 || respError) begin
      check("resp_idle_zero", {respData[30:0], respError}, 32'h0);
    end

    if (memReq) begin
      if (busLen == 0) begin
        if (busQ.size() == 0) begin
          check("unexpected_memreq", 32'd1, 32'd0);
          cur = '{addr: 32'h0, be: 4'h0, wd: 32'h0, wr: 1'b0, len: 0, start: 0};
        end else begin
          cur = busQ.pop_front();
          check("bus_start_cycle", cyc, cur.start);
        end
      end
      check("bus_addr", memAddress, cur.addr);
      check("bus_be", {28'h0, memByteEnable}, {28'h0, cur.be});
      check("bus_wdata", memWriteData, cur.wd);
      check("bus_write_busy", {30'h0, memWrite, busy}, {30'h0, cur.wr, 1'b1});
      if (ackDelay >= 0 && busLen == ackDelay) begin
        memAck = 1'b1;
        memReadData = ackData;
      end else begin
        memAck = 1'b0;
        memReadData = 32'hBAD0BAD0;
      end
      busLen++;
    end else begin
      if (busLen > 0) check("bus_len", busLen, cur.len);
      busLen = 0;
      memAck = 1'b0;
      memReadData = 32'hBAD0BAD0;
      if (memWrite || memByteEnable != 4'h0)
        check("bus_idle_zero", {27'h0, memWrite, memByteEnable}, 32'h0);
    end
  end

  task automatic issue(input logic rd, input logic [31:0] addr, input read_type_t rt,
                       input write_type_t wt, input logic [31:0] wv, input int delay,
                       input logic [31:0] rdata, input logic expBus, input logic [3:0] be,
                       input logic [31:0] wd, input int len, input logic [31:0] expData,
                       input logic expErr, input int lat, input logic expResp);
    int guard = 0;
    bus_t b;
    resp_t r;
    @(negedge clock);
    while (!reqReady && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!reqReady) check("ready_timeout", 32'd0, 32'd1);
    #1;
    ackDelay = delay;
    ackData  = rdata;
    if (expBus) begin
      b.addr = {addr[31:2], 2'b00}; b.be = be; b.wd = wd; b.wr = !rd;
      b.len = len; b.start = cyc + 1;
      busQ.push_back(b);
    end
    if (expResp) begin
      r.data = expData; r.err = expErr; r.cyc = cyc + lat;
      respQ.push_back(r);
    end
    reqValid = 1'b1; reqRead = rd; reqAddress = addr;
    reqReadType = rt; reqWriteType = wt; reqWriteValue = wv;
    @(posedge clock);
    #1;
    reqValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqRead = 1'b0; reqAddress = 32'h0;
    reqReadType = BYTE_SIGNED; reqWriteType = WRITE_NONE; reqWriteValue = 32'h0;
    memAck = 1'b0; memReadData = 32'h0;
    repeat (3) @(negedge clock);
    check("reset_ready", {31'h0, reqReady}, 32'd1);
    check("reset_outs", {25'h0, busy, memReq, memWrite, respValid, memByteEnable[2:0]}, 32'h0);
    check("reset_addr_data", memAddress | memWriteData, 32'h0);
    #1 reset = 1'b0;

    //    rd  addr     rtype               wtype            wval          dly    rdata          bus be       wdata         len   data          err lat     resp
    issue(1, 'h103,   BYTE_SIGNED,        WRITE_NONE,      'h0,          0,     'h80FF1234,    1, 4'b0000, 'h0,          1,    'hFFFFFF80,   0, 2,      1);
    issue(0, 'h202,   BYTE_SIGNED,        WRITE_HALF_WORD, 'h0000ABCD,   0,     'hFFFFFFFF,    1, 4'b1100, 'hABCDABCD,   1,    'h0,          0, 2,      1);
    issue(0, 'h204,   BYTE_SIGNED,        WRITE_HALF_WORD, 'h1234BEEF,   0,     'hFFFFFFFF,    1, 4'b0011, 'hBEEFBEEF,   1,    'h0,          0, 2,      1);
    issue(1, 'h301,   ORIGIN_WORD,        WRITE_NONE,      'h0,          -1,    'h0,           0, 4'b0000, 'h0,          0,    'h0,          1, 1,      1);
    issue(0, 'h400,   BYTE_SIGNED,        WRITE_WORD,      'h11223344,   -1,    'h0,           1, 4'b1111, 'h11223344,   TO,   'h0,          1, TO + 1, 1);
    issue(1, 'h010,   HALF_WORD_UNSIGNED, WRITE_NONE,      'h0,          TO - 1,'h12348001,    1, 4'b0000, 'h0,          TO,   'h00008001,   0, TO + 1, 1);
    issue(1, 'h012,   HALF_WORD_SIGNED,   WRITE_NONE,      'h0,          2,     'h80017FFF,    1, 4'b0000, 'h0,          3,    'hFFFF8001,   0, 4,      1);
    issue(1, 'h021,   BYTE_UNSIGNED,      WRITE_NONE,      'h0,          0,     'h0000A500,    1, 4'b0000, 'h0,          1,    'h000000A5,   0, 2,      1);
    issue(0, 'h033,   BYTE_SIGNED,        WRITE_BYTE,      'h1234565A,   1,     'hFFFFFFFF,    1, 4'b1000, 'h5A5A5A5A,   2,    'h0,          0, 3,      1);
    issue(0, 'h040,   BYTE_SIGNED,        WRITE_NONE,      'hFFFFFFFF,   -1,    'h0,           0, 4'b0000, 'h0,          0,    'h0,          0, 1,      1);
    issue(0, 'h201,   BYTE_SIGNED,        WRITE_HALF_WORD, 'h00001111,   -1,    'h0,           0, 4'b0000, 'h0,          0,    'h0,          1, 1,      1);
    issue(1, 'h500,   ORIGIN_WORD,        WRITE_NONE,      'h0,          0,     'hDEADBEEF,    1, 4'b0000, 'h0,          1,    'hDEADBEEF,   0, 2,      1);
    issue(0, 'h502,   BYTE_SIGNED,        WRITE_WORD,      'h00000001,   -1,    'h0,           0, 4'b0000, 'h0,          0,    'h0,          1, 1,      1);

    // Reset lands in the second ISSUE cycle of a store that is never acknowledged.
    issue(0, 'h600,   BYTE_SIGNED,        WRITE_WORD,      'hCAFEF00D,   -1,    'h0,           1, 4'b1111, 'hCAFEF00D,   2,    'h0,          0, 0,      0);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("reset_mid_memreq", {31'h0, memReq}, 32'h0);
    check("reset_mid_ready_busy", {30'h0, reqReady, busy}, 32'd2);
    check("reset_mid_addr", memAddress, 32'h0);
    @(negedge clock);
    #1 reset = 1'b0;

    issue(1, 'h700,   BYTE_SIGNED,        WRITE_NONE,      'h0,          0,     'h0000007F,    1, 4'b0000, 'h0,          1,    'h0000007F,   0, 2,      1);

    repeat (5) @(negedge clock);
    check("resp_queue_empty", respQ.size(), 32'd0);
    check("bus_queue_empty", busQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
